pixel_dispatcher: RTL and testbench

PIXEL_DISPATCHER -- requirements
Module: pixel_dispatcher

---
 rtl/julia_pkg.sv | 39 +++
 rtl/coord_stepper.sv | 62 ++++++
 rtl/pixel_dispatcher.sv | 122 ++++++++++++
 tb/tb_pixel_dispatcher.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// Shared types and defaults for the Julia-set frame renderer.
// Coordinates are Q16.16 two's-complement. Adds and subtracts wrap on purpose:
// there is no saturation anywhere in the coordinate path.
package julia_pkg;

  // Q16.16 fixed-point coordinate
  typedef logic signed [31:0] q16_16_t;

  // Default screen geometry
  localparam int H_RES_DEFAULT = 640;
  localparam int V_RES_DEFAULT = 480;

  // Linear framebuffer address width. 640*480-1 = 307199 fits in 19 bits.
  localparam int ADDR_W = 19;

  // Number of WAIT_ACK cycles with calc_done still high before the request is re-issued
  localparam int ACK_TIMEOUT = 4;

  // Dispatcher control states
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    WRITE,
    FRAME_END
  } state_t;

  // Wrapping Q16.16 add
  function automatic q16_16_t q_add(input q16_16_t a, input q16_16_t b);
    return a + b;
  endfunction

  // Wrapping Q16.16 subtract
  function automatic q16_16_t q_sub(input q16_16_t a, input q16_16_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/coord_stepper.sv
// Raster walker. It tracks column, row and linear address, and keeps the
// complex-plane coordinate of the current pixel. init loads the top-left
// pixel. advance moves to the next pixel in raster order. The stepper stays
// on the last pixel, so the address never passes H_RES*V_RES-1.
module coord_stepper
  import julia_pkg::*;
#(
  parameter int      H_RES = H_RES_DEFAULT,
  parameter int      V_RES = V_RES_DEFAULT,
  parameter q16_16_t X_MIN = 32'shFFFE_0000,
  parameter q16_16_t Y_MAX = 32'sh0001_8000,
  parameter q16_16_t STEP  = 32'sh0000_0199
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                init,
  input  logic                advance,
  output logic signed [31:0]  z_real,
  output logic signed [31:0]  z_imag,
  output logic [ADDR_W-1:0]   addr,
  output logic                last
);

  logic [15:0] col;
  logic [15:0] row;
  logic        col_end;
  logic        row_end;

  assign col_end = (col == 16'(H_RES - 1));
  assign row_end = (row == 16'(V_RES - 1));
  assign last    = col_end && row_end;

  // Raster position and coordinates: load on init, otherwise step on each completed pixel
  always_ff @(posedge CLK) begin
    if (RESET) begin
      col    <= '0;
      row    <= '0;
      z_real <= '0;
      z_imag <= '0;
      addr   <= '0;
    end else if (init) begin
      col    <= '0;
      row    <= '0;
      z_real <= X_MIN;
      z_imag <= Y_MAX;
      addr   <= '0;
    end else if (advance && !last) begin
      addr <= addr + ADDR_W'(1);
      if (col_end) begin
        // End of line: return to the left edge and move down one line (imaginary axis decreases)
        col    <= '0;
        z_real <= X_MIN;
        row    <= row + 16'd1;
        z_imag <= q_sub(z_imag, STEP);
      end else begin
        col    <= col + 16'd1;
        z_real <= q_add(z_real, STEP);
      end
    end
  end

endmodule

// File: rtl/pixel_dispatcher.sv
// Frame sequencer for the Julia renderer. For each pixel it hands z0 and the
// constant c to an external iteration engine, waits for the result, and
// writes the intensity to the framebuffer in raster order. The constant c is
// latched at frame start, so a frame always renders one Julia set even if the
// inputs change while the frame is in progress.
module pixel_dispatcher
  import julia_pkg::*;
#(
  parameter int      H_RES = H_RES_DEFAULT,
  parameter int      V_RES = V_RES_DEFAULT,
  parameter q16_16_t X_MIN = 32'shFFFE_0000,
  parameter q16_16_t Y_MAX = 32'sh0001_8000,
  parameter q16_16_t STEP  = 32'sh0000_0199
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                frame_start,
  input  logic signed [31:0]  real_var_in,
  input  logic signed [31:0]  imag_var_in,
  output logic                calc_start,
  output logic signed [31:0]  calc_z_real,
  output logic signed [31:0]  calc_z_imag,
  output logic signed [31:0]  calc_real_var,
  output logic signed [31:0]  calc_imag_var,
  input  logic                calc_done,
  input  logic [7:0]          calc_intensity,
  output logic                fb_we,
  output logic [18:0]         fb_addr,
  output logic [7:0]          fb_data,
  input  logic                fb_ready,
  output logic                busy,
  output logic                frame_done
);

  state_t      state;
  state_t      state_next;
  logic [1:0]  ack_cnt;
  logic        ack_expired;
  logic        start_frame;
  logic        write_done;
  logic        pixel_last;

  // A frame starts only from IDLE. A start request while busy is ignored.
  assign start_frame = (state == IDLE) && frame_start;
  // The write handshake completes in the cycle where fb_we and fb_ready are both high
  assign write_done  = (state == WRITE) && fb_ready;
  // The engine never dropped calc_done, so it probably missed the request
  assign ack_expired = (ack_cnt == 2'(ACK_TIMEOUT - 1));

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (frame_start) state_next = ISSUE;
      ISSUE:     state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (!calc_done)       state_next = WAIT_DONE;
        else if (ack_expired) state_next = ISSUE;
      end
      WAIT_DONE: if (calc_done) state_next = WRITE;
      WRITE:     if (fb_ready) state_next = pixel_last ? FRAME_END : ISSUE;
      FRAME_END: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    calc_start = (state == ISSUE);
    fb_we      = (state == WRITE);
    busy       = (state != IDLE);
    frame_done = (state == FRAME_END);
  end

  // Acknowledge watchdog: counts WAIT_ACK cycles in which calc_done is still high
  always_ff @(posedge CLK) begin
    if (RESET)                  ack_cnt <= '0;
    else if (state != WAIT_ACK) ack_cnt <= '0;
    else if (calc_done)         ack_cnt <= ack_cnt + 2'd1;
  end

  // Julia constant, captured once per frame so the engine never sees the live inputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      calc_real_var <= '0;
      calc_imag_var <= '0;
    end else if (start_frame) begin
      calc_real_var <= real_var_in;
      calc_imag_var <= imag_var_in;
    end
  end

  // Result capture: intensity is valid in the cycle calc_done rises. It is held through WRITE.
  always_ff @(posedge CLK) begin
    if (RESET)                                 fb_data <= '0;
    else if ((state == WAIT_DONE) && calc_done) fb_data <= calc_intensity;
  end

  coord_stepper #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .X_MIN (X_MIN),
    .Y_MAX (Y_MAX),
    .STEP  (STEP)
  ) u_stepper (
    .CLK     (CLK),
    .RESET   (RESET),
    .init    (start_frame),
    .advance (write_done),
    .z_real  (calc_z_real),
    .z_imag  (calc_z_imag),
    .addr    (fb_addr),
    .last    (pixel_last)
  );

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Scoreboard bench for pixel_dispatcher on a 4x2 screen. An engine model
// answers calc_start after a fixed latency and returns intensity = 10 * pixel
// index, where the index is recovered from z0. Expected framebuffer writes
// are queued when a request is accepted and popped on each completed write.
module tb_pixel_dispatcher;

  localparam int H   = 4;
  localparam int V   = 2;
  localparam int LAT = 5;
  localparam logic signed [31:0] XMIN = 32'shFFFE_0000;
  localparam logic signed [31:0] YMAX = 32'sh0001_8000;
  localparam logic signed [31:0] STP  = 32'sh0000_0199;

  logic               CLK = 1'b0;
  logic               RESET;
  logic               frame_start;
  logic signed [31:0] real_var_in, imag_var_in;
  logic               calc_start;
  logic signed [31:0] calc_z_real, calc_z_imag, calc_real_var, calc_imag_var;
  logic               calc_done;
  logic [7:0]         calc_intensity;
  logic               fb_we;
  logic [18:0]        fb_addr;
  logic [7:0]         fb_data;
  logic               fb_ready;
  logic               busy, frame_done;

  pixel_dispatcher #(.H_RES(H), .V_RES(V)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .frame_start    (frame_start),
    .real_var_in    (real_var_in),
    .imag_var_in    (imag_var_in),
    .calc_start     (calc_start),
    .calc_z_real    (calc_z_real),
    .calc_z_imag    (calc_z_imag),
    .calc_real_var  (calc_real_var),
    .calc_imag_var  (calc_imag_var),
    .calc_done      (calc_done),
    .calc_intensity (calc_intensity),
    .fb_we          (fb_we),
    .fb_addr        (fb_addr),
    .fb_data        (fb_data),
    .fb_ready       (fb_ready),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t                sb[$];
  wr_t                w;
  int                 exp_pix = 0;
  int                 frames_done = 0;
  int                 eng_cnt = 0;
  int                 eng_col, eng_row;
  logic [7:0]         eng_val;
  int                 ign_cyc = -1;
  bit                 ign_used = 1'b0;
  bit                 stall_used = 1'b0;
  int                 stall_n = 0;
  logic [18:0]        st_addr;
  logic [7:0]         st_data;
  bit                 chk_after_done = 1'b0;
  logic signed [31:0] exp_cr = '0, exp_ci = '0;

  // Engine model, fb_ready driver and write/frame monitor, all sampled on the falling edge
  initial begin
    calc_done = 1'b1;
    calc_intensity = '0;
    fb_ready = 1'b1;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        sb.delete();
        exp_pix = 0;
        eng_cnt = 0;
        calc_done = 1'b1;
        fb_ready = 1'b1;
        chk_after_done = 1'b0;
      end else begin
        if (chk_after_done) begin
          check("busy_after_done", 32'(busy), 0);
          check("done_one_cycle", 32'(frame_done), 0);
          chk_after_done = 1'b0;
        end
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            calc_done = 1'b1;
            calc_intensity = eng_val;
          end
        end
        if (calc_start) begin
          check("z_real", calc_z_real, XMIN + (exp_pix % H) * STP);
          check("z_imag", calc_z_imag, YMAX - (exp_pix / H) * STP);
          check("c_real", calc_real_var, exp_cr);
          check("c_imag", calc_imag_var, exp_ci);
          if (frames_done == 0 && exp_pix == 0) begin
            check("first_z_real", calc_z_real, 32'hFFFE_0000);
            check("first_z_imag", calc_z_imag, 32'h0001_8000);
            check("first_c_real", calc_real_var, 32'hFFFF_3333);
          end
          if (exp_pix == 4) begin
            check("wrap_z_real", calc_z_real, 32'hFFFE_0000);
            check("wrap_z_imag", calc_z_imag, 32'h0001_7E67);
          end
          if (frames_done == 1 && !ign_used) begin
            ign_used = 1'b1;
            ign_cyc = cyc;
          end else begin
            if (ign_cyc >= 0) begin
              check("reissue_gap", cyc - ign_cyc, 5);
              ign_cyc = -1;
            end
            w.addr = 19'(exp_pix);
            w.data = 8'(exp_pix * 10);
            sb.push_back(w);
            eng_col = int'((calc_z_real - XMIN) / STP);
            eng_row = int'((YMAX - calc_z_imag) / STP);
            eng_val = 8'((eng_row * H + eng_col) * 10);
            calc_done = 1'b0;
            eng_cnt = LAT;
          end
        end
        if (frames_done == 1 && !stall_used && !fb_we && exp_pix == 0) begin
          fb_ready = 1'b0;
          stall_used = 1'b1;
        end
        if (fb_we && !fb_ready) begin
          if (stall_n == 7) fb_ready = 1'b1;
          else begin
            stall_n++;
            if (stall_n == 1) begin
              st_addr = fb_addr;
              st_data = fb_data;
            end else begin
              check("stall_addr", 32'(fb_addr), 32'(st_addr));
              check("stall_data", 32'(fb_data), 32'(st_data));
            end
          end
        end
        if (fb_we && fb_ready) begin
          if (sb.size() == 0) check("write_expected", sb.size(), 1);
          else begin
            w = sb.pop_front();
            check("wr_addr", 32'(fb_addr), 32'(w.addr));
            check("wr_data", 32'(fb_data), 32'(w.data));
          end
          exp_pix++;
        end
        if (frame_done) begin
          frames_done++;
          check("frame_pixels", exp_pix, H * V);
          check("sb_empty", sb.size(), 0);
          exp_pix = 0;
          chk_after_done = 1'b1;
        end
      end
    end
  end

  task automatic start_frame(input logic signed [31:0] cr, input logic signed [31:0] ci);
    real_var_in = cr;
    imag_var_in = ci;
    exp_cr = cr;
    exp_ci = ci;
    frame_start = 1'b1;
    @(posedge CLK); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 3000 && frames_done < n; i++) begin
      @(posedge CLK); #1;
    end
    check("frames_done", frames_done, n);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_calc_start"}, 32'(calc_start), 0);
    check({tag, "_fb_we"}, 32'(fb_we), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_fb_addr"}, 32'(fb_addr), 0);
    check({tag, "_fb_data"}, 32'(fb_data), 0);
    check({tag, "_z_real"}, calc_z_real, 0);
    check({tag, "_z_imag"}, calc_z_imag, 0);
    check({tag, "_c_real"}, calc_real_var, 0);
    check({tag, "_c_imag"}, calc_imag_var, 0);
  endtask

  initial begin
    RESET = 1'b1;
    frame_start = 1'b0;
    real_var_in = 32'sh7777_7777;
    imag_var_in = 32'sh5555_5555;
    repeat (3) @(posedge CLK);
    #1;
    check_idle_outputs("reset");
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Frame 1: plain frame
    start_frame(32'shFFFF_3333, 32'sh0000_9999);
    check("busy_in_frame", 32'(busy), 1);
    wait_frames(1);

    // Frame 2: first request ignored, first write stalled, start request mid-frame
    @(posedge CLK); #1;
    start_frame(32'sh0000_4000, 32'shFFFF_C000);
    for (int i = 0; i < 1000 && exp_pix < 2; i++) begin
      @(posedge CLK); #1;
    end
    real_var_in = 32'sh1234_5678;
    imag_var_in = 32'sh0ABC_DEF0;
    frame_start = 1'b1;
    @(posedge CLK); #1;
    frame_start = 1'b0;
    wait_frames(2);
    check("stall_cycles", stall_n, 7);
    check("reissue_seen", 32'(ign_used), 1);

    // Frame 3: reset while waiting on the engine for pixel 3
    @(posedge CLK); #1;
    start_frame(32'sh0000_1000, 32'sh0000_2000);
    for (int i = 0; i < 1000 && !(exp_pix == 3 && eng_cnt == 3); i++) begin
      @(posedge CLK); #1;
    end
    check("reach_wait_done", 32'(exp_pix == 3 && eng_cnt == 3), 1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    check_idle_outputs("midreset");
    @(posedge CLK); #1;
    RESET = 1'b0;
    exp_cr = '0;
    exp_ci = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("no_frame_after_reset", frames_done, 2);

    // Frame 4: restart from address 0
    start_frame(32'shFFFF_8000, 32'sh0000_0800);
    wait_frames(3);
    repeat (3) @(posedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
